fetch_unit: RTL and testbench

- Multi-cycle instruction fetch sequencer. Owns the PC and acts on the taken/not-taken decision and target from the branch unit.
- Issues one request at a time to instruction memory, buffers one returned instruction toward decode with a valid/ready handshake, and discards stale responses after a redirect.
- Traps on a misaligned redirect target.

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Multi-cycle instruction fetch sequencer. Owns the PC, issues
//                one request at a time to instruction memory, buffers one
//                returned instruction toward decode (valid/ready), discards
//                stale responses after a redirect and traps on a misaligned
//                redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    // Branch resolution
    input  logic        br_valid,
    input  logic        nextPcSrc,
    input  logic [31:0] br_target,
    // Instruction memory
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    // Decode interface
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    // Status
    output logic        pc_fault
);

    // BOOT   : one idle cycle after reset release
    // FETCH  : request pulse on the memory port
    // WAIT   : live request outstanding
    // HOLD   : instruction buffered toward decode
    // DROP   : stale request outstanding, its response is thrown away
    // TRAP   : misaligned redirect seen, parked until reset
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DROP  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] inst_pc_q,    inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        pc_fault_q,   pc_fault_d;

    logic        w_redirect;
    logic        w_misalign;
    logic        w_redirect_live;

    // Redirect qualification; a redirect only counts in the states that own
    // a fetch stream (BOOT ignores it, TRAP is terminal).
    always_comb begin
        w_redirect      = br_valid & nextPcSrc;
        w_misalign      = (br_target[1:0] != 2'b00);
        w_redirect_live = w_redirect && (state_q != S_BOOT) && (state_q != S_TRAP);
    end

    // Next-state, PC update and decode buffer update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_fault_d   = pc_fault_q;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end

            // The request is considered issued this cycle no matter what, so
            // a redirect here leaves a stale response to be drained in DROP.
            S_FETCH: begin
                if (w_redirect) begin
                    pc_d    = br_target;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_redirect) begin
                    pc_d    = br_target;
                    // Response in the same cycle is the stale one: nothing
                    // left outstanding, so the new stream can start at once.
                    state_d = imem_rvalid ? S_FETCH : S_DROP;
                end else if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + PC_STEP;
                    state_d      = S_HOLD;
                end
            end

            // Redirect wins over a simultaneous accept; the PC already points
            // past the buffered instruction for the sequential case.
            S_HOLD: begin
                if (w_redirect) begin
                    inst_valid_d = 1'b0;
                    pc_d         = br_target;
                    state_d      = S_FETCH;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end

            S_DROP: begin
                if (w_redirect) begin
                    pc_d = br_target;
                end
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end

            S_TRAP: begin
                inst_valid_d = 1'b0;
                pc_fault_d   = 1'b1;
            end

            default: begin
                state_d      = S_BOOT;
                inst_valid_d = 1'b0;
            end
        endcase

        // A misaligned target overrides whatever the state logic chose; the
        // target is still latched into pc so it can be inspected afterwards.
        if (w_redirect_live && w_misalign) begin
            state_d      = S_TRAP;
            pc_d         = br_target;
            pc_fault_d   = 1'b1;
            inst_valid_d = 1'b0;
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
            pc_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            pc_fault_q   <= pc_fault_d;
        end
    end

    // Outputs come from registers or a pure state decode only
    always_comb begin
        imem_req   = (state_q == S_FETCH);
        imem_addr  = pc_q;
        inst_valid = inst_valid_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        pc_fault   = pc_fault_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        nextPcSrc;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        pc_fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .nextPcSrc   (nextPcSrc),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .pc_fault    (pc_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; returns on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        br_valid  = 1'b1;
        nextPcSrc = 1'b1;
        br_target = tgt;
    endtask

    task automatic clear_inputs();
        br_valid    = 1'b0;
        nextPcSrc   = 1'b0;
        br_target   = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);

        // ---- Reset state ----
        check("rst_req",   {31'b0, imem_req},   32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst",  inst,                32'h0);
        check("rst_ipc",   inst_pc,             32'h0);
        check("rst_fault", {31'b0, pc_fault},   32'd0);
        check("rst_addr",  imem_addr,           32'h0);

        // ---- Basic fetch, latency 1 ----
        rst_n = 1'b1;                         // cycle 0: BOOT
        check("boot_req", {31'b0, imem_req}, 32'd0);
        tick();                               // cycle 1: FETCH
        check("c1_req",  {31'b0, imem_req}, 32'd1);
        check("c1_addr", imem_addr,         32'h0);
        tick();                               // cycle 2: WAIT
        check("c2_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();                               // cycle 3: HOLD
        clear_inputs();
        check("c3_valid", {31'b0, inst_valid}, 32'd1);
        check("c3_inst",  inst,                32'h0000_0013);
        check("c3_ipc",   inst_pc,             32'h0);
        inst_ready = 1'b1;
        tick();                               // cycle 4: FETCH
        inst_ready = 1'b0;
        check("c4_valid", {31'b0, inst_valid}, 32'd0);
        check("c4_req",   {31'b0, imem_req},   32'd1);
        check("c4_addr",  imem_addr,           32'h4);

        // ---- Decode back-pressure ----
        tick();                               // WAIT
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hAAAA_0001;
        tick();                               // HOLD
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, inst_valid}, 32'd1);
            check("bp_inst",  inst,                32'hAAAA_0001);
            check("bp_ipc",   inst_pc,             32'h4);
            check("bp_req",   {31'b0, imem_req},   32'd0);
            // Stray response while holding must be ignored
            imem_rvalid = (i == 2);
            imem_rdata  = 32'h5555_5555;
            tick();
        end
        clear_inputs();
        check("bp_hold_inst", inst, 32'hAAAA_0001);
        inst_ready = 1'b1;
        tick();                               // FETCH
        inst_ready = 1'b0;
        check("bp_req_after", {31'b0, imem_req}, 32'd1);
        check("bp_addr_after", imem_addr,        32'h8);

        // ---- Redirect in WAIT, stale response two cycles later ----
        tick();                               // WAIT
        redirect(32'h0000_0100);
        tick();                               // DROP
        clear_inputs();
        check("drop_req1", {31'b0, imem_req}, 32'd0);
        tick();                               // DROP
        check("drop_req2", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();                               // FETCH
        clear_inputs();
        check("drop_valid", {31'b0, inst_valid}, 32'd0);
        check("drop_inst",  inst,                32'hAAAA_0001);
        check("drop_req3",  {31'b0, imem_req},   32'd1);
        check("drop_addr",  imem_addr,           32'h100);
        tick();                               // WAIT
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();                               // HOLD
        clear_inputs();
        check("rd_inst", inst,    32'h1111_1111);
        check("rd_ipc",  inst_pc, 32'h100);
        inst_ready = 1'b1;
        tick();                               // FETCH
        inst_ready = 1'b0;
        check("rd_next_addr", imem_addr, 32'h104);

        // ---- Redirect and response together in WAIT ----
        tick();                               // WAIT
        redirect(32'h0000_0040);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        tick();                               // FETCH
        clear_inputs();
        check("rv_req",   {31'b0, imem_req},   32'd1);
        check("rv_addr",  imem_addr,           32'h40);
        check("rv_valid", {31'b0, inst_valid}, 32'd0);
        check("rv_inst",  inst,                32'h1111_1111);

        // ---- Not-taken branch has no effect ----
        tick();                               // WAIT
        br_valid    = 1'b1;
        nextPcSrc   = 1'b0;
        br_target   = 32'h0000_0300;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        tick();                               // HOLD
        clear_inputs();
        check("nt_valid", {31'b0, inst_valid}, 32'd1);
        check("nt_inst",  inst,                32'h3333_3333);
        check("nt_ipc",   inst_pc,             32'h40);

        // ---- Redirect in HOLD beats inst_ready ----
        inst_ready = 1'b1;
        redirect(32'h0000_0080);
        tick();                               // FETCH
        inst_ready = 1'b0;
        clear_inputs();
        check("hr_valid", {31'b0, inst_valid}, 32'd0);
        check("hr_req",   {31'b0, imem_req},   32'd1);
        check("hr_addr",  imem_addr,           32'h80);

        // ---- Misaligned redirect traps ----
        redirect(32'h0000_0102);
        tick();                               // TRAP
        clear_inputs();
        check("tr_fault", {31'b0, pc_fault},   32'd1);
        check("tr_req",   {31'b0, imem_req},   32'd0);
        check("tr_valid", {31'b0, inst_valid}, 32'd0);
        check("tr_pc",    imem_addr,           32'h102);
        for (int i = 0; i < 4; i++) begin
            imem_rvalid = (i == 0);
            imem_rdata  = 32'h4444_4444;
            if (i == 1) redirect(32'h0000_0200);
            tick();
            clear_inputs();
            check("tr_stay_req",   {31'b0, imem_req}, 32'd0);
            check("tr_stay_fault", {31'b0, pc_fault}, 32'd1);
        end

        // ---- Asynchronous reset clears the trap ----
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_fault", {31'b0, pc_fault}, 32'd0);
        check("ar_req",   {31'b0, imem_req}, 32'd0);
        check("ar_addr",  imem_addr,         32'h0);
        check("ar_inst",  inst,              32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;                         // BOOT
        tick();                               // FETCH
        check("rs_req",  {31'b0, imem_req}, 32'd1);
        check("rs_addr", imem_addr,         32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
